// File: rtl/ifq.sv
//------------------------------------------------------------------------------
// Module   : ifq
// Brief    : Instruction fetch queue with one-deep in-flight IRAM tracker and
//            credit-based fetch stall.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ifq #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       fetch_req_i,
  input  logic [XLEN-1:0]            pc_data_i,
  input  logic [XLEN-1:0]            pc_next_i,
  input  logic [XLEN-1:0]            iram_rd_data_i,
  input  logic                       flush_i,
  input  logic                       dec_ready_i,
  output logic                       fetch_stall_o,
  output logic                       inst_valid_o,
  output logic [XLEN-1:0]            inst_data_o,
  output logic [XLEN-1:0]            inst_pc_o,
  output logic [XLEN-1:0]            inst_pc_next_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_EXT = (CW+1)'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_inf_pc;
  logic [XLEN-1:0] r_inf_pc_next;

  logic [XLEN-1:0] r_mem_data    [DEPTH];
  logic [XLEN-1:0] r_mem_pc      [DEPTH];
  logic [XLEN-1:0] r_mem_pc_next [DEPTH];

  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic [CW:0]     w_credit;

  // An in-flight fetch already owns a slot, so it counts against the credit.
  assign w_credit      = {1'b0, r_count} + {{CW{1'b0}}, (r_state == S_WAIT)};
  assign fetch_stall_o = (w_credit >= DEPTH_EXT);

  assign w_accept = fetch_req_i && !fetch_stall_o && !flush_i;
  assign w_push   = (r_state == S_WAIT) && !flush_i;
  assign w_pop    = inst_valid_o && dec_ready_i && !flush_i;

  assign inst_valid_o   = (r_count != '0);
  assign inst_data_o    = inst_valid_o ? r_mem_data[r_rd_ptr]    : '0;
  assign inst_pc_o      = inst_valid_o ? r_mem_pc[r_rd_ptr]      : '0;
  assign inst_pc_next_o = inst_valid_o ? r_mem_pc_next[r_rd_ptr] : '0;
  assign count_o        = r_count;

  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_state_nxt = S_WAIT;
        S_WAIT:  if (!w_accept) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_inf_pc      <= '0;
      r_inf_pc_next <= '0;
    end else if (w_accept) begin
      r_inf_pc      <= pc_data_i;
      r_inf_pc_next <= pc_next_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left unreset; the head outputs are masked while empty.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr]    <= iram_rd_data_i;
      r_mem_pc[r_wr_ptr]      <= r_inf_pc;
      r_mem_pc_next[r_wr_ptr] <= r_inf_pc_next;
    end
  end

endmodule

`default_nettype wire
